// File: rtl/cpu_io_port.sv
// ----------------------------------------------------------------------------
// cpu_io_port
//   On-chip processor I/O port. PORTS banks of direction + data registers are
//   decoded at BASE (DIR[k] at BASE+2k, DATA[k] at BASE+2k+1). The block sits
//   between the CPU core and the system bus. It intercepts register accesses
//   and muxes port read data into the core. Any other access passes through to
//   the bus.
//   Masked input bits that float (FADE_MASK) keep their last driven level for
//   FADE_CYCLES enable cycles and then read 0. A write to a port register drives
//   the last byte read onto the bus instead of the core data.
//
//   Optional feature macro: CPU_IO_PORT_IRQ_EN
//     When it is defined, IMASK[k] and ISTAT[k] live at BASE+2*PORTS+2k and
//     BASE+2*PORTS+2k+1. Falling edges on input-direction pins latch into
//     ISTAT. Writing 1 to an ISTAT bit clears it. irq_n is a registered,
//     active-low OR of ISTAT & IMASK.
//     When it is undefined, those addresses are unmapped and irq_n is tied to 1.
//
// Ports
//   clk        in   system clock
//   reset_n    in   synchronous active-low reset (overrides enable)
//   enable     in   CPU clock enable, qualifies every register update
//   address    in   CPU address [ADDR_W]
//   rw         in   1 = read, 0 = write
//   core_dout  in   write data from the core [WIDTH]
//   bus_din    in   read data from the system bus [WIDTH]
//   core_din   out  read data to the core (combinational mux) [WIDTH]
//   bus_dout   out  write data to the system bus (combinational) [WIDTH]
//   sel        out  address hits a port register (combinational)
//   port_in    in   pin levels, port k at [k*WIDTH +: WIDTH]
//   port_out   out  data registers, packed like port_in
//   port_dir   out  direction registers (1 = output), packed like port_in
//   irq_n      out  active-low interrupt
// ----------------------------------------------------------------------------
module cpu_io_port #(
    parameter int                 WIDTH       = 8,
    parameter int                 PORTS       = 1,
    parameter int                 ADDR_W      = 16,
    parameter logic [ADDR_W-1:0]  BASE        = 16'h0000,
    parameter logic [WIDTH-1:0]   FADE_MASK   = 8'hC0,
    parameter int                 FADE_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [ADDR_W-1:0]        address,
    input  logic                     rw,
    input  logic [WIDTH-1:0]         core_dout,
    input  logic [WIDTH-1:0]         bus_din,
    output logic [WIDTH-1:0]         core_din,
    output logic [WIDTH-1:0]         bus_dout,
    output logic                     sel,
    input  logic [PORTS*WIDTH-1:0]   port_in,
    output logic [PORTS*WIDTH-1:0]   port_out,
    output logic [PORTS*WIDTH-1:0]   port_dir,
    output logic                     irq_n
);

    localparam int               CNT_W     = $clog2(FADE_CYCLES + 1);
    localparam logic [CNT_W-1:0] FADE_LOAD = CNT_W'(FADE_CYCLES);

    logic [WIDTH-1:0]  dir_q      [PORTS];
    logic [WIDTH-1:0]  dir_d      [PORTS];
    logic [WIDTH-1:0]  data_q     [PORTS];
    logic [WIDTH-1:0]  data_d     [PORTS];
    logic [WIDTH-1:0]  held_q     [PORTS];
    logic [WIDTH-1:0]  held_d     [PORTS];
    logic [CNT_W-1:0]  fade_cnt_q [PORTS];
    logic [CNT_W-1:0]  fade_cnt_d [PORTS];
    logic [WIDTH-1:0]  pin_s      [PORTS];
    logic [WIDTH-1:0]  last_read_q;
    logic [WIDTH-1:0]  last_read_d;

    logic [ADDR_W-1:0] offset_s;
    logic [PORTS-1:0]  dir_hit_s;
    logic [PORTS-1:0]  data_hit_s;
    logic              irq_sel_s;
    logic [WIDTH-1:0]  irq_rd_s;
    logic [WIDTH-1:0]  port_rd_s;
    logic              wr_s;

    // Address decode of the direction/data registers relative to BASE.
    always_comb begin
        offset_s = address - BASE;
        for (int k = 0; k < PORTS; k++) begin
            dir_hit_s[k]  = (offset_s == ADDR_W'(2 * k));
            data_hit_s[k] = (offset_s == ADDR_W'(2 * k + 1));
        end
        sel   = (|dir_hit_s) | (|data_hit_s) | irq_sel_s;
        wr_s  = enable & ~rw;
    end

    // Pin view seen by the core: outputs read DATA, floating masked bits read
    // the held level while the fade counter runs, other inputs read the pins.
    always_comb begin
        for (int k = 0; k < PORTS; k++) begin
            pin_s[k] = (dir_q[k] & data_q[k])
                     | (~dir_q[k] & FADE_MASK
                        & ((fade_cnt_q[k] != {CNT_W{1'b0}}) ? held_q[k] : {WIDTH{1'b0}}))
                     | (~dir_q[k] & ~FADE_MASK & port_in[k*WIDTH +: WIDTH]);
        end
    end

    // Read data mux and bus write-data selection.
    always_comb begin
        port_rd_s = {WIDTH{1'b0}};
        for (int k = 0; k < PORTS; k++) begin
            port_rd_s = port_rd_s
                      | (dir_hit_s[k]  ? dir_q[k] : {WIDTH{1'b0}})
                      | (data_hit_s[k] ? pin_s[k] : {WIDTH{1'b0}});
        end
        core_din = (sel & rw) ? (port_rd_s | irq_rd_s) : bus_din;
        // A port-register write leaks the last byte read onto the bus.
        bus_dout = (sel & ~rw) ? last_read_q : core_dout;
    end

    // Next-state logic for registers, held fade bits and fade counters.
    always_comb begin
        for (int k = 0; k < PORTS; k++) begin
            dir_d[k]  = (wr_s & dir_hit_s[k])  ? core_dout : dir_q[k];
            data_d[k] = (wr_s & data_hit_s[k]) ? core_dout : data_q[k];
            // While a bit is an output its held value follows DATA.
            held_d[k] = enable ? ((dir_q[k] & data_q[k]) | (~dir_q[k] & held_q[k])) : held_q[k];
            // A masked bit turning from output to input restarts the fade; the
            // reload takes priority over the running decrement.
            if (|(dir_q[k] & ~dir_d[k] & FADE_MASK)) begin
                fade_cnt_d[k] = FADE_LOAD;
            end else if (enable && (fade_cnt_q[k] != {CNT_W{1'b0}})) begin
                fade_cnt_d[k] = fade_cnt_q[k] - CNT_W'(1'b1);
            end else begin
                fade_cnt_d[k] = fade_cnt_q[k];
            end
        end
        last_read_d = (enable & rw) ? core_din : last_read_q;
    end

    // Port state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < PORTS; k++) begin
                dir_q[k]      <= {WIDTH{1'b0}};
                data_q[k]     <= {WIDTH{1'b0}};
                held_q[k]     <= {WIDTH{1'b0}};
                fade_cnt_q[k] <= {CNT_W{1'b0}};
            end
            last_read_q <= {WIDTH{1'b0}};
        end else begin
            for (int k = 0; k < PORTS; k++) begin
                dir_q[k]      <= dir_d[k];
                data_q[k]     <= data_d[k];
                held_q[k]     <= held_d[k];
                fade_cnt_q[k] <= fade_cnt_d[k];
            end
            last_read_q <= last_read_d;
        end
    end

    // Pack register arrays onto the flat output buses.
    always_comb begin
        for (int k = 0; k < PORTS; k++) begin
            port_out[k*WIDTH +: WIDTH] = data_q[k];
            port_dir[k*WIDTH +: WIDTH] = dir_q[k];
        end
    end

`ifdef CPU_IO_PORT_IRQ_EN
    logic [WIDTH-1:0] imask_q    [PORTS];
    logic [WIDTH-1:0] imask_d    [PORTS];
    logic [WIDTH-1:0] istat_q    [PORTS];
    logic [WIDTH-1:0] istat_d    [PORTS];
    logic [WIDTH-1:0] pin_prev_q [PORTS];
    logic [WIDTH-1:0] pin_prev_d [PORTS];
    logic [PORTS-1:0] imask_hit_s;
    logic [PORTS-1:0] istat_hit_s;
    logic             irq_n_q;
    logic             irq_n_d;
    logic             pending_s;

    // Interrupt register decode, read data and next-state logic.
    always_comb begin
        irq_rd_s  = {WIDTH{1'b0}};
        pending_s = 1'b0;
        for (int k = 0; k < PORTS; k++) begin
            imask_hit_s[k] = (offset_s == ADDR_W'(2 * PORTS + 2 * k));
            istat_hit_s[k] = (offset_s == ADDR_W'(2 * PORTS + 2 * k + 1));
            irq_rd_s = irq_rd_s
                     | (imask_hit_s[k] ? imask_q[k] : {WIDTH{1'b0}})
                     | (istat_hit_s[k] ? istat_q[k] : {WIDTH{1'b0}});
            imask_d[k]    = (wr_s & imask_hit_s[k]) ? core_dout : imask_q[k];
            pin_prev_d[k] = enable ? port_in[k*WIDTH +: WIDTH] : pin_prev_q[k];
            // Set (falling edge on an input pin) wins over write-1-to-clear.
            istat_d[k] = enable
                       ? ((istat_q[k] & ~((wr_s & istat_hit_s[k]) ? core_dout : {WIDTH{1'b0}}))
                          | (pin_prev_q[k] & ~port_in[k*WIDTH +: WIDTH] & ~dir_q[k]))
                       : istat_q[k];
            pending_s = pending_s | (|(istat_q[k] & imask_q[k]));
        end
        irq_sel_s = (|imask_hit_s) | (|istat_hit_s);
        irq_n_d   = enable ? ~pending_s : irq_n_q;
    end

    // Interrupt state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < PORTS; k++) begin
                imask_q[k]    <= {WIDTH{1'b0}};
                istat_q[k]    <= {WIDTH{1'b0}};
                pin_prev_q[k] <= {WIDTH{1'b0}};
            end
            irq_n_q <= 1'b1;
        end else begin
            for (int k = 0; k < PORTS; k++) begin
                imask_q[k]    <= imask_d[k];
                istat_q[k]    <= istat_d[k];
                pin_prev_q[k] <= pin_prev_d[k];
            end
            irq_n_q <= irq_n_d;
        end
    end

    assign irq_n = irq_n_q;
`else
    assign irq_sel_s = 1'b0;
    assign irq_rd_s  = {WIDTH{1'b0}};
    assign irq_n     = 1'b1;
`endif

endmodule

// File: tb/tb_cpu_io_port.sv
// ----------------------------------------------------------------------------
// tb_cpu_io_port
//   Directed test of cpu_io_port with WIDTH=8, PORTS=1, BASE=0,
//   FADE_MASK=C0 and FADE_CYCLES=16. Inputs change 1 time unit after the
//   rising edge, and outputs are sampled there too. The interrupt steps
//   exist only when CPU_IO_PORT_IRQ_EN is defined.
// ----------------------------------------------------------------------------
module tb_cpu_io_port;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] address;
    logic        rw;
    logic [7:0]  core_dout;
    logic [7:0]  bus_din;
    logic [7:0]  core_din;
    logic [7:0]  bus_dout;
    logic        sel;
    logic [7:0]  port_in;
    logic [7:0]  port_out;
    logic [7:0]  port_dir;
    logic        irq_n;

    int checks   = 0;
    int failures = 0;

`ifdef CPU_IO_PORT_IRQ_EN
    localparam logic [15:0] UNMAPPED = 16'h0004;
`else
    localparam logic [15:0] UNMAPPED = 16'h0002;
`endif

    cpu_io_port #(
        .WIDTH(8), .PORTS(1), .ADDR_W(16), .BASE(16'h0000),
        .FADE_MASK(8'hC0), .FADE_CYCLES(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .address(address),
        .rw(rw), .core_dout(core_dout), .bus_din(bus_din), .core_din(core_din),
        .bus_dout(bus_dout), .sel(sel), .port_in(port_in), .port_out(port_out),
        .port_dir(port_dir), .irq_n(irq_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        address   = a;
        rw        = 1'b0;
        core_dout = d;
        tick();
        rw      = 1'b1;
        address = UNMAPPED;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
        address = a;
        rw      = 1'b1;
        #1;
        chk(tag, core_din, exp);
    endtask

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        address   = UNMAPPED;
        rw        = 1'b1;
        core_dout = 8'h00;
        bus_din   = 8'h00;
        port_in   = 8'h00;
        tick();
        tick();
        reset_n = 1'b1;
        enable  = 1'b1;

        // Reset state
        chk("rst_port_out", port_out, 8'h00);
        chk("rst_port_dir", port_dir, 8'h00);
        chk("rst_irq_n", {7'h00, irq_n}, 8'h01);
        rd_chk("rst_read_dir", 16'h0000, 8'h00);
        chk("rst_sel", {7'h00, sel}, 8'h01);

        // Basic write/read with mixed directions
        wr(16'h0000, 8'h0F);
        wr(16'h0001, 8'hA5);
        port_in = 8'h3C;
        #1;
        chk("port_out_a5", port_out, 8'hA5);
        chk("port_dir_0f", port_dir, 8'h0F);
        rd_chk("read_dir", 16'h0000, 8'h0F);
        rd_chk("read_pin_35", 16'h0001, 8'h35);

        // Bus read of 5A, then port write leaks it onto the bus
        bus_din = 8'h5A;
        rd_chk("bus_read_5a", UNMAPPED, 8'h5A);
        chk("bus_read_sel", {7'h00, sel}, 8'h00);
        tick();
        address   = 16'h0001;
        rw        = 1'b0;
        core_dout = 8'h11;
        #1;
        chk("leak_bus_dout", bus_dout, 8'h5A);
        tick();
        chk("data_after_leak", port_out, 8'h11);

        // Unmapped write: core data passes to the bus, no register change
        address   = UNMAPPED;
        rw        = 1'b0;
        core_dout = 8'h33;
        #1;
        chk("unmapped_bus_dout", bus_dout, 8'h33);
        chk("unmapped_wr_sel", {7'h00, sel}, 8'h00);
        tick();
        chk("unmapped_data_kept", port_out, 8'h11);
        chk("unmapped_dir_kept", port_dir, 8'h0F);
        bus_din = 8'h77;
        rd_chk("unmapped_read_77", UNMAPPED, 8'h77);

        // Fade of floating bits 7:6
        port_in = 8'h00;
        wr(16'h0000, 8'hC0);
        wr(16'h0001, 8'hC0);
        wr(16'h0000, 8'h00);
        for (int i = 0; i < 8; i++) begin
            rd_chk("fade_hold_a", 16'h0001, 8'hC0);
            tick();
        end
        enable = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rd_chk("fade_stall_hold", 16'h0001, 8'hC0);
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_chk("fade_hold_b", 16'h0001, 8'hC0);
            tick();
        end
        rd_chk("fade_expired", 16'h0001, 8'h00);

        // Reset in mid-fade clears the counter and registers
        wr(16'h0000, 8'hC0);
        wr(16'h0000, 8'h00);
        rd_chk("fade_restart", 16'h0001, 8'hC0);
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        rd_chk("fade_after_reset", 16'h0001, 8'h00);
        chk("port_out_after_reset", port_out, 8'h00);

`ifdef CPU_IO_PORT_IRQ_EN
        // Falling edge on pin 0 with IMASK=01
        wr(16'h0002, 8'h01);
        port_in = 8'h01;
        tick();
        port_in = 8'h00;
        tick();
        rd_chk("istat_set", 16'h0003, 8'h01);
        chk("irq_n_latency", {7'h00, irq_n}, 8'h01);
        tick();
        chk("irq_n_low", {7'h00, irq_n}, 8'h00);
        wr(16'h0003, 8'h01);
        rd_chk("istat_cleared", 16'h0003, 8'h00);
        tick();
        chk("irq_n_high", {7'h00, irq_n}, 8'h01);
        // Edge in the same cycle as a clear: set wins
        port_in = 8'h01;
        tick();
        port_in = 8'h00;
        wr(16'h0003, 8'h01);
        rd_chk("istat_set_wins", 16'h0003, 8'h01);
`else
        tick();
        chk("irq_n_tied", {7'h00, irq_n}, 8'h01);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
